rep3_serial_tx: RTL and testbench

- Transmit end of the team's triple-repetition (majority-vote) serial link.
- Accepts a parallel word over a valid/ready handshake and serialises it MSB first.
- Emits each data bit as REP identical consecutive chips, so the far-end receiver can recover each bit with a REP-input majority vote.
- Sits between the word producer and the chip-level line driver; the line driver can stall it via tx_ready.

---
 rtl/rep3_serial_tx.sv | 115 +++++++++++
 tb/tb_rep3_serial_tx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rep3_serial_tx.sv
// rep3_serial_tx: transmit side of the repetition-coded serial link.
// Accepts a word over valid/ready, then sends it MSB first with every data
// bit repeated REP times as consecutive chips, so the receiver can
// majority-vote each bit. The line driver may stall the chip stream.
module rep3_serial_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_first,
  output logic              tx_last,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [2:0]    LAST_CHIP = 3'(REP - 1);

  // Reject illegal parameterisations at elaboration time.
  generate
    if (REP < 1 || REP > 7 || (REP % 2) == 0) begin : g_bad_rep
      $error("rep3_serial_tx: REP must be odd and in 1..7");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
      $error("rep3_serial_tx: DATA_W must be in 1..32");
    end
  endgenerate

  logic [0:0]        state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [2:0]        chip_cnt_reg, chip_cnt_next;

  logic sending;
  logic at_last_chip;
  logic at_last_bit;

  assign sending      = (state_reg == SEND);
  assign at_last_chip = (chip_cnt_reg == LAST_CHIP);
  assign at_last_bit  = (bit_cnt_reg == LAST_BIT);

  // Next-state logic: word capture in IDLE, chip/bit stepping in SEND.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    chip_cnt_next = chip_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next    = SEND;
          shift_next    = in_data;
          bit_cnt_next  = '0;
          chip_cnt_next = '0;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (at_last_chip) begin
            // Final repetition of this bit: move on to the next bit.
            chip_cnt_next = '0;
            shift_next    = shift_reg << 1;
            bit_cnt_next  = bit_cnt_reg + BW'(1);
            if (at_last_bit) begin
              // Frame complete: clear counters so nothing wraps.
              state_next   = IDLE;
              bit_cnt_next = '0;
            end
          end else begin
            chip_cnt_next = chip_cnt_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      chip_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      chip_cnt_reg <= chip_cnt_next;
    end
  end

  // Outputs are decoded purely from registered state, so tx_ready and
  // in_valid never reach an output combinationally.
  assign in_ready = ~sending;
  assign busy     = sending;
  assign tx_valid = sending;
  assign tx_bit   = sending & shift_reg[DATA_W-1];
  assign tx_first = sending & (bit_cnt_reg == '0) & (chip_cnt_reg == '0);
  assign tx_last  = sending & at_last_bit & at_last_chip;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Bench for rep3_serial_tx: three instances (8x3, 4x5, 1x1) share clock,
// reset and tx_ready; a chip-sequence model built from the word checks them.
module tb_rep3_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tx_ready;

  logic [7:0] in_data0;
  logic       in_valid0;
  logic       in_ready0, tx_bit0, tx_valid0, tx_first0, tx_last0, busy0;
  logic [3:0] in_data1;
  logic       in_valid1;
  logic       in_ready1, tx_bit1, tx_valid1, tx_first1, tx_last1, busy1;
  logic [0:0] in_data2;
  logic       in_valid2;
  logic       in_ready2, tx_bit2, tx_valid2, tx_first2, tx_last2, busy2;

  rep3_serial_tx #(.DATA_W(8), .REP(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .tx_bit(tx_bit0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready), .tx_first(tx_first0), .tx_last(tx_last0), .busy(busy0));

  rep3_serial_tx #(.DATA_W(4), .REP(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx_bit(tx_bit1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready), .tx_first(tx_first1), .tx_last(tx_last1), .busy(busy1));

  rep3_serial_tx #(.DATA_W(1), .REP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .tx_bit(tx_bit2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready), .tx_first(tx_first2), .tx_last(tx_last2), .busy(busy2));

  int sel;
  logic c_valid, c_bit, c_first, c_last, c_ready, c_busy;

  // Route the selected instance's outputs to the common observation bus.
  always_comb begin
    c_valid = tx_valid0; c_bit = tx_bit0; c_first = tx_first0;
    c_last  = tx_last0;  c_ready = in_ready0; c_busy = busy0;
    if (sel == 1) begin
      c_valid = tx_valid1; c_bit = tx_bit1; c_first = tx_first1;
      c_last  = tx_last1;  c_ready = in_ready1; c_busy = busy1;
    end else if (sel == 2) begin
      c_valid = tx_valid2; c_bit = tx_bit2; c_first = tx_first2;
      c_last  = tx_last2;  c_ready = in_ready2; c_busy = busy2;
    end
  end

  int errors = 0;
  int checks = 0;

  // Collected frame: chips packed in transmit order (earliest chip is the MSB side).
  logic [63:0] got_vec, first_vec, last_vec;
  int          got_n, cycles, stall_bad, frame_bad, busy_bad;
  bit          timed_out, hs_ok;

  // Reference: each data bit, MSB first, repeated rep times.
  function automatic logic [63:0] model_chips(input logic [31:0] d, input int w, input int rep);
    logic [63:0] v;
    v = '0;
    for (int b = w - 1; b >= 0; b--)
      for (int r = 0; r < rep; r++)
        v = {v[62:0], d[b]};
    return v;
  endfunction

  // Offer a word to the selected instance and wait (bounded) for the handshake.
  task automatic start_word(input int s, input logic [31:0] d, input bit hold);
    sel   = s;
    hs_ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s == 0) begin in_valid0 = 1'b1; in_data0 = d[7:0]; end
      else if (s == 1) begin in_valid1 = 1'b1; in_data1 = d[3:0]; end
      else begin in_valid2 = 1'b1; in_data2 = d[0:0]; end
      if (c_ready === 1'b1) begin hs_ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    if (!hold) begin in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0; end
  endtask

  // Record chips until tx_last (or max_chips), optionally with random stalls.
  task automatic collect(input bit stall_en, input int max_chips, input int change_at);
    bit have_prev, done, r;
    logic pb, pf, pl;
    got_vec = '0; first_vec = '0; last_vec = '0;
    got_n = 0; cycles = 0; stall_bad = 0; frame_bad = 0; busy_bad = 0;
    timed_out = 1'b0; have_prev = 1'b0; done = 1'b0;
    pb = 1'b0; pf = 1'b0; pl = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      cycles++;
      if (change_at >= 0 && got_n == change_at) in_data0 = 8'h00;
      if (c_busy !== ~c_ready) busy_bad++;
      if (c_valid !== 1'b1 || c_ready !== 1'b0) frame_bad++;
      if (have_prev && (c_bit !== pb || c_first !== pf || c_last !== pl)) stall_bad++;
      r = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready = r;
      if (r) begin
        have_prev = 1'b0;
        got_vec   = {got_vec[62:0], c_bit};
        first_vec = {first_vec[62:0], c_first};
        last_vec  = {last_vec[62:0], c_last};
        got_n++;
        if (c_last === 1'b1 || got_n == max_chips) begin done = 1'b1; break; end
      end else begin
        have_prev = 1'b1; pb = c_bit; pf = c_first; pl = c_last;
      end
    end
    if (!done) timed_out = 1'b1;
    if (stall_en) begin
      @(negedge clk);
      tx_ready = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; tx_ready = 1'b1; sel = 0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    in_data0 = '0; in_data1 = '0; in_data2 = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready0, tx_valid0, tx_bit0, tx_first0, tx_last0, busy0} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=100000",
               {in_ready0, tx_valid0, tx_bit0, tx_first0, tx_last0, busy0});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1 || tx_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle in_ready=%b tx_valid=%b want 1/0", in_ready0, tx_valid0);
    end
    $display("test_reset done");
  endtask

  task automatic test_a5_nostall;
    start_word(0, 32'hA5, 1'b0);
    collect(1'b0, 64, -1);
    checks++;
    if (!hs_ok || timed_out || got_n != 24 || got_vec[23:0] !== 24'b111000111000000111000111) begin
      errors++;
      $display("FAIL a5_chips n=%0d got=%b want 111000111000000111000111", got_n, got_vec[23:0]);
    end
    checks++;
    if (first_vec !== (64'd1 << 23) || last_vec !== 64'd1) begin
      errors++;
      $display("FAIL a5_first_last first=%h last=%h", first_vec, last_vec);
    end
    checks++;
    if (cycles != 24 || frame_bad != 0 || busy_bad != 0) begin
      errors++;
      $display("FAIL a5_timing cycles=%0d want 24 frame_bad=%0d busy_bad=%0d", cycles, frame_bad, busy_bad);
    end
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1 || tx_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL a5_return_idle in_ready=%b tx_valid=%b busy=%b", in_ready0, tx_valid0, busy0);
    end
    $display("test_a5_nostall word=a5 chips=%0d cycles=%0d", got_n, cycles);
  endtask

  task automatic test_stall;
    start_word(0, 32'h3C, 1'b0);
    collect(1'b1, 64, -1);
    checks++;
    if (timed_out || got_n != 24 || got_vec[23:0] !== model_chips(32'h3C, 8, 3)) begin
      errors++;
      $display("FAIL stall_chips n=%0d got=%b want %b", got_n, got_vec[23:0], model_chips(32'h3C, 8, 3));
    end
    checks++;
    if (stall_bad != 0 || frame_bad != 0 || first_vec !== (64'd1 << 23) || last_vec !== 64'd1) begin
      errors++;
      $display("FAIL stall_stability stall_bad=%0d frame_bad=%0d want 0/0", stall_bad, frame_bad);
    end
    $display("test_stall word=3c chips=%0d cycles=%0d", got_n, cycles);
  endtask

  task automatic test_back_to_back;
    start_word(0, 32'hFF, 1'b1);
    in_data0 = 8'h00;
    collect(1'b0, 64, -1);
    checks++;
    if (timed_out || got_n != 24 || got_vec[23:0] !== 24'hFFFFFF || frame_bad != 0) begin
      errors++;
      $display("FAIL b2b_first n=%0d got=%h want ffffff frame_bad=%0d", got_n, got_vec[23:0], frame_bad);
    end
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1 || tx_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap in_ready=%b tx_valid=%b want 1/0", in_ready0, tx_valid0);
    end
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    collect(1'b0, 64, -1);
    checks++;
    if (timed_out || got_n != 24 || got_vec[23:0] !== 24'h000000 || frame_bad != 0 || first_vec !== (64'd1 << 23)) begin
      errors++;
      $display("FAIL b2b_second n=%0d got=%h want 000000 frame_bad=%0d", got_n, got_vec[23:0], frame_bad);
    end
    $display("test_back_to_back words=ff,00 second_chips=%0d", got_n);
  endtask

  task automatic test_data_change;
    start_word(0, 32'hA5, 1'b0);
    collect(1'b0, 64, 5);
    checks++;
    if (timed_out || got_n != 24 || got_vec[23:0] !== model_chips(32'hA5, 8, 3)) begin
      errors++;
      $display("FAIL data_change got=%b want %b", got_vec[23:0], model_chips(32'hA5, 8, 3));
    end
    $display("test_data_change word=a5 chips=%0d", got_n);
  endtask

  task automatic test_reset_midframe;
    start_word(0, 32'hA5, 1'b0);
    collect(1'b0, 10, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset tx_valid=%b in_ready=%b busy=%b want 0/1/0", tx_valid0, in_ready0, busy0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_word(0, 32'h81, 1'b0);
    collect(1'b0, 64, -1);
    checks++;
    if (timed_out || got_n != 24 || got_vec[23:0] !== model_chips(32'h81, 8, 3) ||
        first_vec !== (64'd1 << 23) || last_vec !== 64'd1) begin
      errors++;
      $display("FAIL after_reset n=%0d got=%b want %b first=%h", got_n, got_vec[23:0],
               model_chips(32'h81, 8, 3), first_vec);
    end
    $display("test_reset_midframe resumed word=81 chips=%0d", got_n);
  endtask

  task automatic test_w4_r5;
    start_word(1, 32'h9, 1'b0);
    collect(1'b0, 64, -1);
    checks++;
    if (timed_out || got_n != 20 || cycles != 20 || got_vec[19:0] !== 20'b11111000000000011111) begin
      errors++;
      $display("FAIL w4r5_chips n=%0d cycles=%0d got=%b want 11111000000000011111", got_n, cycles, got_vec[19:0]);
    end
    checks++;
    if (first_vec !== (64'd1 << 19) || last_vec !== 64'd1) begin
      errors++;
      $display("FAIL w4r5_first_last first=%h last=%h", first_vec, last_vec);
    end
    $display("test_w4_r5 word=9 chips=%0d", got_n);
  endtask

  task automatic test_w1_r1;
    for (int k = 0; k < 2; k++) begin
      start_word(2, 32'(k ^ 1), 1'b0);
      collect(1'b0, 64, -1);
      checks++;
      if (timed_out || got_n != 1 || got_vec[0] !== 1'(k ^ 1) || first_vec !== 64'd1 || last_vec !== 64'd1) begin
        errors++;
        $display("FAIL w1r1 n=%0d bit=%b want %0d first=%h last=%h", got_n, got_vec[0], k ^ 1, first_vec, last_vec);
      end
      $display("test_w1_r1 word=%0d chips=%0d", k ^ 1, got_n);
    end
  endtask

  task automatic test_random;
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      if (k % 2 == 0) begin
        start_word(0, d, 1'b0);
        collect(1'b1, 64, -1);
        checks++;
        if (timed_out || got_n != 24 || got_vec[23:0] !== model_chips(d, 8, 3) || stall_bad != 0 || frame_bad != 0) begin
          errors++;
          $display("FAIL random8 word=%h got=%b want %b stall_bad=%0d", d[7:0], got_vec[23:0], model_chips(d, 8, 3), stall_bad);
        end
        $display("test_random w8 word=%h chips=%0d", d[7:0], got_n);
      end else begin
        start_word(1, d, 1'b0);
        collect(1'b1, 64, -1);
        checks++;
        if (timed_out || got_n != 20 || got_vec[19:0] !== model_chips(d, 4, 5) || stall_bad != 0 || frame_bad != 0) begin
          errors++;
          $display("FAIL random4 word=%h got=%b want %b stall_bad=%0d", d[3:0], got_vec[19:0], model_chips(d, 4, 5), stall_bad);
        end
        $display("test_random w4 word=%h chips=%0d", d[3:0], got_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5_nostall();
    test_stall();
    test_back_to_back();
    test_data_change();
    test_reset_midframe();
    test_w4_r5();
    test_w1_r1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
